// File: rtl/dr_alt_pkg.sv
// Shared types and helpers for the alternating-spacer dual-rail receiver.
package dr_alt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SPC  = 2'd1,
    DAT  = 2'd2
  } state_e;

  // Parity values carried on SP: odd tokens expect zeros, even tokens expect ones.
  localparam logic SPACER_ZERO = 1'b1;
  localparam logic SPACER_ONE  = 1'b0;

  function automatic logic pair_valid(input logic d1, input logic d0);
    return d1 ^ d0;
  endfunction

  function automatic logic pair_decode(input logic d1, input logic d0);
    return d1 & ~d0;
  endfunction

endpackage

// File: rtl/dr_alt_rx_fifo.sv
// Small synchronous FIFO with a registered head word and registered non-empty flag.
module dr_alt_rx_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         ready,
  output logic         push_ok,
  output logic [W-1:0] head,
  output logic         head_valid
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [W-1:0]  head_q, head_d;
  logic          valid_q, valid_d;
  logic          pop, full;

  always_comb begin
    pop      = valid_q & ready;
    full     = (cnt_q == (AW+1)'(DEPTH));
    push_ok  = push & (~full | pop);
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok && !pop) cnt_d = cnt_q + (AW+1)'(1);
    else if (!push_ok && pop) cnt_d = cnt_q - (AW+1)'(1);
    valid_d = (cnt_d != '0);
    // The new head may be the word being written this very cycle.
    head_d = head_q;
    if (cnt_d != '0) begin
      if (push_ok && (wr_ptr_q == rd_ptr_d)) head_d = wdata;
      else head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
    end
  end

  assign head       = head_q;
  assign head_valid = valid_q;

endmodule

// File: rtl/dr_alt_rx.sv
// Alternating-spacer dual-rail receiver: spacer/codeword checking, decode, output FIFO.
// Define DR_ALT_RX_ERRCNT_EN to add the saturating ERR_CNT error-event counter port.
module dr_alt_rx
  import dr_alt_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         C,
  input  logic         RN,
  output logic         SP,
  input  logic         EN,
  input  logic [W-1:0] D_1,
  input  logic [W-1:0] D_0,
  output logic [W-1:0] Q,
  output logic         Q_VALID,
  input  logic         Q_READY,
  output logic         ERR_SPACER,
  output logic         ERR_CODE,
  output logic         ERR_OVF,
  input  logic         ERR_CLR
`ifdef DR_ALT_RX_ERRCNT_EN
  ,
  output logic [7:0]   ERR_CNT
`endif
);

  state_e       state_q, state_d;
  logic         parity_q, parity_d;
  logic         err_spc_q, err_spc_d;
  logic         err_code_q, err_code_d;
  logic         err_ovf_q, err_ovf_d;
  logic [W-1:0] valid_bits, dec_bits;
  logic         spc_ok, word_ok, push, push_ok;
  logic         ev_spc, ev_code, ev_ovf;

  for (genvar gi = 0; gi < W; gi++) begin : g_pair
    assign valid_bits[gi] = pair_valid(D_1[gi], D_0[gi]);
    assign dec_bits[gi]   = pair_decode(D_1[gi], D_0[gi]);
  end

  always_comb begin
    spc_ok  = (parity_q == SPACER_ZERO) ? ((D_1 == '0) && (D_0 == '0))
                                        : ((D_1 == '1) && (D_0 == '1));
    word_ok = &valid_bits;
    state_d  = state_q;
    parity_d = parity_q;
    push     = 1'b0;
    ev_spc   = 1'b0;
    ev_code  = 1'b0;
    case (state_q)
      IDLE: if (EN) state_d = SPC;
      SPC: begin
        if (!EN) state_d = IDLE;
        else if (spc_ok) state_d = DAT;
        else ev_spc = 1'b1;
      end
      DAT: begin
        // The token always completes here, even if EN dropped meanwhile.
        if (word_ok) push = 1'b1;
        else ev_code = 1'b1;
        parity_d = ~parity_q;
        state_d  = EN ? SPC : IDLE;
      end
      default: state_d = IDLE;
    endcase
    ev_ovf     = push & ~push_ok;
    err_spc_d  = (err_spc_q & ~ERR_CLR) | ev_spc;
    err_code_d = (err_code_q & ~ERR_CLR) | ev_code;
    err_ovf_d  = (err_ovf_q & ~ERR_CLR) | ev_ovf;
  end

  always_ff @(posedge C) begin
    if (!RN) begin
      state_q    <= IDLE;
      parity_q   <= SPACER_ZERO;
      err_spc_q  <= 1'b0;
      err_code_q <= 1'b0;
      err_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      parity_q   <= parity_d;
      err_spc_q  <= err_spc_d;
      err_code_q <= err_code_d;
      err_ovf_q  <= err_ovf_d;
    end
  end

  dr_alt_rx_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (C),
    .rst_n      (RN),
    .push       (push),
    .wdata      (dec_bits),
    .ready      (Q_READY),
    .push_ok    (push_ok),
    .head       (Q),
    .head_valid (Q_VALID)
  );

`ifdef DR_ALT_RX_ERRCNT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       err_any;

  always_comb begin
    err_any = ev_spc | ev_code | ev_ovf;
    cnt_d   = cnt_q;
    if (ERR_CLR) cnt_d = err_any ? 8'd1 : 8'd0;
    else if (err_any && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge C) begin
    if (!RN) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end

  assign ERR_CNT = cnt_q;
`endif

  assign SP         = parity_q;
  assign ERR_SPACER = err_spc_q;
  assign ERR_CODE   = err_code_q;
  assign ERR_OVF    = err_ovf_q;

endmodule

// File: tb/tb_dr_alt_rx.sv
// Directed self-checking bench for dr_alt_rx (W=8, DEPTH=4).
module tb_dr_alt_rx;

  logic       C = 1'b0;
  logic       RN, EN, Q_READY, ERR_CLR;
  logic [7:0] D_1, D_0, Q;
  logic       SP, Q_VALID, ERR_SPACER, ERR_CODE, ERR_OVF;
`ifdef DR_ALT_RX_ERRCNT_EN
  logic [7:0] ERR_CNT;
`endif

  int   n_cmp = 0;
  int   n_bad = 0;
  logic exp_sp;
  logic [7:0] w;

  always #5 C = ~C;

  dr_alt_rx #(.W(8), .DEPTH(4)) dut (
    .C          (C),
    .RN         (RN),
    .SP         (SP),
    .EN         (EN),
    .D_1        (D_1),
    .D_0        (D_0),
    .Q          (Q),
    .Q_VALID    (Q_VALID),
    .Q_READY    (Q_READY),
    .ERR_SPACER (ERR_SPACER),
    .ERR_CODE   (ERR_CODE),
    .ERR_OVF    (ERR_OVF),
    .ERR_CLR    (ERR_CLR)
`ifdef DR_ALT_RX_ERRCNT_EN
    ,
    .ERR_CNT    (ERR_CNT)
`endif
  );

  task automatic tick();
    @(posedge C);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full token using the spacer the bench expects for the current parity.
  task automatic tok(input logic [7:0] d1, input logic [7:0] d0);
    D_1 = exp_sp ? 8'h00 : 8'hFF;
    D_0 = D_1;
    tick();
    D_1 = d1;
    D_0 = d0;
    tick();
    exp_sp = ~exp_sp;
    $display("token d1=%h d0=%h -> SP=%b Q=%h Q_VALID=%b", d1, d0, SP, Q, Q_VALID);
    chk1("sp_after_token", SP, exp_sp);
  endtask

  // Clear flags while parked: SPC/IDLE -> IDLE -> SPC.
  task automatic clr();
    EN = 1'b0;
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;
    EN = 1'b1;
    tick();
    chk1("clr_spacer", ERR_SPACER, 1'b0);
    chk1("clr_code", ERR_CODE, 1'b0);
    chk1("clr_ovf", ERR_OVF, 1'b0);
  endtask

  initial begin
    RN = 1'b0; EN = 1'b0; Q_READY = 1'b1; ERR_CLR = 1'b0; D_1 = 8'h00; D_0 = 8'h00;
    exp_sp = 1'b1;
    tick();
    tick();
    chk1("rst_sp", SP, 1'b1);
    chk1("rst_qvalid", Q_VALID, 1'b0);
    chk8("rst_q", Q, 8'h00);
    chk1("rst_err_spacer", ERR_SPACER, 1'b0);
    chk1("rst_err_code", ERR_CODE, 1'b0);
    chk1("rst_err_ovf", ERR_OVF, 1'b0);
`ifdef DR_ALT_RX_ERRCNT_EN
    chk8("rst_cnt", ERR_CNT, 8'h00);
`endif
    RN = 1'b1;
    EN = 1'b1;
    tick();

    // 1: two good tokens
    tok(8'hA5, 8'h5A);
    chk1("t1_valid_a", Q_VALID, 1'b1);
    chk8("t1_q_a", Q, 8'hA5);
    tok(8'h3C, 8'hC3);
    chk1("t1_valid_b", Q_VALID, 1'b1);
    chk8("t1_q_b", Q, 8'h3C);
    chk1("t1_no_spc_err", ERR_SPACER, 1'b0);
    chk1("t1_no_code_err", ERR_CODE, 1'b0);

    // 2: wrong spacer on an even token, then recovery
    tok(8'h11, 8'hEE);
    chk8("t2_q_pre", Q, 8'h11);
    D_1 = 8'h00; D_0 = 8'h00;
    tick();
    $display("bad spacer -> ERR_SPACER=%b SP=%b", ERR_SPACER, SP);
    chk1("t2_err_spacer", ERR_SPACER, 1'b1);
    chk1("t2_sp_held", SP, 1'b0);
    tok(8'h96, 8'h69);
    chk8("t2_q_recover", Q, 8'h96);
    chk1("t2_valid", Q_VALID, 1'b1);
    chk1("t2_no_code_err", ERR_CODE, 1'b0);
    clr();

    // 3: invalid pairs in the data cycle
    tok(8'h01, 8'h01);
    chk1("t3_err_code", ERR_CODE, 1'b1);
    chk1("t3_no_push", Q_VALID, 1'b0);
    chk8("t3_q_held", Q, 8'h96);
    chk1("t3_no_spc_err", ERR_SPACER, 1'b0);
    clr();

    // 4a: overflow with consumer stalled
    Q_READY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      w = 8'h10 + 8'(i);
      tok(w, ~w);
      if (i == 3) chk1("t4_no_ovf_at_full", ERR_OVF, 1'b0);
    end
    chk1("t4_ovf", ERR_OVF, 1'b1);
    chk8("t4_head", Q, 8'h10);
    EN = 1'b0;
    Q_READY = 1'b1;
    tick();
    chk8("t4_pop1", Q, 8'h11);
    tick();
    chk8("t4_pop2", Q, 8'h12);
    tick();
    chk8("t4_pop3", Q, 8'h13);
    tick();
    chk1("t4_empty", Q_VALID, 1'b0);
    chk8("t4_q_held", Q, 8'h13);
    clr();

    // 4b: push into a full FIFO while the head is popped
    Q_READY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w = 8'h20 + 8'(i);
      tok(w, ~w);
    end
    D_1 = exp_sp ? 8'h00 : 8'hFF;
    D_0 = D_1;
    tick();
    D_1 = 8'h24; D_0 = 8'hDB; Q_READY = 1'b1;
    tick();
    exp_sp = ~exp_sp;
    Q_READY = 1'b0;
    $display("full push+pop -> ERR_OVF=%b Q=%h", ERR_OVF, Q);
    chk1("t4b_no_ovf", ERR_OVF, 1'b0);
    chk8("t4b_head", Q, 8'h21);
    chk1("t4b_valid", Q_VALID, 1'b1);

    // 5: reset during DAT with two words buffered
    EN = 1'b0;
    Q_READY = 1'b1;
    tick();
    tick();
    chk8("t5_head", Q, 8'h23);
    Q_READY = 1'b0;
    EN = 1'b1;
    tick();
    D_1 = exp_sp ? 8'hFF : 8'h00;
    D_0 = D_1;
    tick();
    chk1("t5_pre_err", ERR_SPACER, 1'b1);
    D_1 = exp_sp ? 8'h00 : 8'hFF;
    D_0 = D_1;
    tick();
    D_1 = 8'h77; D_0 = 8'h88; RN = 1'b0;
    tick();
    $display("reset in DAT -> Q_VALID=%b SP=%b Q=%h", Q_VALID, SP, Q);
    chk1("t5_qvalid", Q_VALID, 1'b0);
    chk1("t5_sp", SP, 1'b1);
    chk8("t5_q", Q, 8'h00);
    chk1("t5_err_spacer", ERR_SPACER, 1'b0);
    RN = 1'b1;
    exp_sp = 1'b1;
    Q_READY = 1'b1;
    tick();
    tok(8'h5A, 8'hA5);
    chk8("t5_after_q", Q, 8'h5A);

`ifdef DR_ALT_RX_ERRCNT_EN
    // 6: counter saturation and clear
    for (int i = 0; i < 300; i++) begin
      D_1 = exp_sp ? 8'hFF : 8'h00;
      D_0 = D_1;
      tick();
    end
    $display("300 spacer errors -> ERR_CNT=%0d", ERR_CNT);
    chk8("t6_sat", ERR_CNT, 8'd255);
    clr();
    chk8("t6_clr", ERR_CNT, 8'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
